// File: rtl/branch_tag_manager.sv
// ---------------------------------------------------------------------------
// branch_tag_manager
//
// Hands out branch tags (index + color bit) to decode, tracks the in-flight
// branches in program order, retires correctly predicted branches from the
// head, and sequences mispredict recovery (tail rollback, one-cycle rename
// checkpoint restore, multi-cycle squash broadcast).
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   alloc_req          decode wants a tag this cycle
//   alloc_ready        a tag is free and no recovery is in progress
//   alloc_id/_color    tag granted when alloc_req && alloc_ready (from tail)
//   resolve_valid      execute resolved a branch
//   resolve_id/_color  tag of the resolved branch
//   resolve_miss       the branch was mispredicted
//   squash_valid       kill everything younger than squash_id
//   squash_id/_color   mispredicted tag
//   restore_valid      one-cycle pulse: restore rename checkpoint squash_id
//   recover_busy       recovery in progress
//   retire_valid       one-cycle pulse: retire_id freed
//   retire_id          freed tag
//   inflight_count     allocated, not yet retired tags
// ---------------------------------------------------------------------------
module branch_tag_manager #(
  parameter int ID_W           = 3,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_req,
  output logic            alloc_ready,
  output logic [ID_W-1:0] alloc_id,
  output logic            alloc_color,
  input  logic            resolve_valid,
  input  logic [ID_W-1:0] resolve_id,
  input  logic            resolve_color,
  input  logic            resolve_miss,
  output logic            squash_valid,
  output logic [ID_W-1:0] squash_id,
  output logic            squash_color,
  output logic            restore_valid,
  output logic            recover_busy,
  output logic            retire_valid,
  output logic [ID_W-1:0] retire_id,
  output logic [ID_W:0]   inflight_count
);

  localparam int NUM_IDS = 1 << ID_W;
  localparam int PTR_W   = ID_W + 1;
  localparam int CNT_W   = $clog2(RECOVER_CYCLES + 1);

  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(NUM_IDS);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(RECOVER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_RECOVER = 1'b1
  } state_t;

  // Age of pointer p relative to the head; smaller means older.
  function automatic logic [PTR_W-1:0] f_age(input logic [PTR_W-1:0] p,
                                             input logic [PTR_W-1:0] h);
    return p - h;
  endfunction

  // State
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [NUM_IDS-1:0] r_valid;
  logic [NUM_IDS-1:0] r_resolved;
  logic [NUM_IDS-1:0] r_color;
  logic [ID_W-1:0]    r_sq_id;
  logic               r_sq_color;
  logic               r_restore;
  logic               r_retire_valid;
  logic [ID_W-1:0]    r_retire_id;

  // Combinational
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [PTR_W-1:0]   w_count;
  logic               w_full;
  logic [PTR_W-1:0]   w_res_ptr;
  logic               w_res_ok;
  logic               w_res_older;
  logic               w_miss_take;
  logic               w_alloc_fire;
  logic [ID_W-1:0]    w_head_idx;
  logic               w_retire;
  logic [PTR_W-1:0]   w_new_tail;
  logic [PTR_W-1:0]   w_kill_n;
  logic [NUM_IDS-1:0] w_kill;

  assign w_count    = r_tail - r_head;
  assign w_full     = (w_count == FULL_CNT);
  assign w_res_ptr  = {resolve_color, resolve_id};

  // A resolve is only trusted when the slot is live and of the same
  // generation (color); anything else refers to a rolled-back or retired tag.
  assign w_res_ok   = resolve_valid && r_valid[resolve_id] &&
                      (r_color[resolve_id] == resolve_color);

  assign w_res_older = f_age(w_res_ptr, r_head) <
                       f_age({r_sq_color, r_sq_id}, r_head);

  // During recovery only a miss older than the one being squashed matters;
  // a repeated miss on the squash tag itself just marks it resolved.
  assign w_miss_take = w_res_ok && resolve_miss &&
                       ((r_state == S_IDLE) || w_res_older);

  // A mispredict in the same cycle wins over allocation: the tail rolls back
  // past the slot that would have been written.
  assign w_alloc_fire = alloc_req && alloc_ready && !w_miss_take;

  assign w_head_idx = r_head[ID_W-1:0];
  assign w_retire   = r_valid[w_head_idx] && r_resolved[w_head_idx];

  assign w_new_tail = w_res_ptr + PTR_W'(1);
  assign w_kill_n   = r_tail - w_new_tail;

  // Slots in [new_tail, old_tail) are younger than the mispredicted branch.
  always_comb begin
    w_kill = '0;
    if (w_miss_take) begin
      for (int i = 0; i < NUM_IDS; i++) begin
        if ({1'b0, ID_W'(i) - w_new_tail[ID_W-1:0]} < w_kill_n)
          w_kill[i] = 1'b1;
      end
    end
  end

  // Recovery FSM: next state and counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_miss_take) begin
          w_state_nxt = S_RECOVER;
          w_cnt_nxt   = RELOAD;
        end
      end
      S_RECOVER: begin
        if (w_miss_take) begin
          w_cnt_nxt = RELOAD;
        end else if (r_cnt == CNT_ONE) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pointers, squash latch and output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_sq_id        <= '0;
      r_sq_color     <= 1'b0;
      r_restore      <= 1'b0;
      r_retire_valid <= 1'b0;
      r_retire_id    <= '0;
    end else begin
      if (w_retire)
        r_head <= r_head + PTR_W'(1);

      if (w_miss_take)
        r_tail <= w_new_tail;
      else if (w_alloc_fire)
        r_tail <= r_tail + PTR_W'(1);

      if (w_miss_take) begin
        r_sq_id    <= resolve_id;
        r_sq_color <= resolve_color;
      end

      r_restore      <= w_miss_take;
      r_retire_valid <= w_retire;
      if (w_retire)
        r_retire_id <= w_head_idx;
    end
  end

  // Per-entry state. Later assignments win: kill and retire clear valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_resolved <= '0;
      r_color    <= '0;
    end else begin
      if (w_res_ok)
        r_resolved[resolve_id] <= 1'b1;

      if (w_alloc_fire) begin
        r_valid[r_tail[ID_W-1:0]]    <= 1'b1;
        r_resolved[r_tail[ID_W-1:0]] <= 1'b0;
        r_color[r_tail[ID_W-1:0]]    <= r_tail[ID_W];
      end

      for (int i = 0; i < NUM_IDS; i++) begin
        if (w_kill[i])
          r_valid[i] <= 1'b0;
      end

      if (w_retire)
        r_valid[w_head_idx] <= 1'b0;
    end
  end

  assign alloc_ready    = !w_full && (r_state == S_IDLE);
  assign alloc_id       = r_tail[ID_W-1:0];
  assign alloc_color    = r_tail[ID_W];
  assign squash_valid   = (r_state == S_RECOVER);
  assign recover_busy   = (r_state == S_RECOVER);
  assign squash_id      = r_sq_id;
  assign squash_color   = r_sq_color;
  assign restore_valid  = r_restore;
  assign retire_valid   = r_retire_valid;
  assign retire_id      = r_retire_id;
  assign inflight_count = w_count;

endmodule

// File: tb/tb_branch_tag_manager.sv
// Directed bench for branch_tag_manager (ID_W = 3, RECOVER_CYCLES = 2).
// Each table row gives the inputs driven for one clock and the outputs
// expected during that clock, i.e. before the edge that consumes the inputs.
module tb_branch_tag_manager;

  localparam int ID_W = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            alloc_req;
  logic            alloc_ready;
  logic [ID_W-1:0] alloc_id;
  logic            alloc_color;
  logic            resolve_valid;
  logic [ID_W-1:0] resolve_id;
  logic            resolve_color;
  logic            resolve_miss;
  logic            squash_valid;
  logic [ID_W-1:0] squash_id;
  logic            squash_color;
  logic            restore_valid;
  logic            recover_busy;
  logic            retire_valid;
  logic [ID_W-1:0] retire_id;
  logic [ID_W:0]   inflight_count;

  branch_tag_manager #(.ID_W(ID_W), .RECOVER_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_req      (alloc_req),
    .alloc_ready    (alloc_ready),
    .alloc_id       (alloc_id),
    .alloc_color    (alloc_color),
    .resolve_valid  (resolve_valid),
    .resolve_id     (resolve_id),
    .resolve_color  (resolve_color),
    .resolve_miss   (resolve_miss),
    .squash_valid   (squash_valid),
    .squash_id      (squash_id),
    .squash_color   (squash_color),
    .restore_valid  (restore_valid),
    .recover_busy   (recover_busy),
    .retire_valid   (retire_valid),
    .retire_id      (retire_id),
    .inflight_count (inflight_count)
  );

  always #5 clk = ~clk;

  // Output bundle: {ar, aid[3], acol, sq, sqid[3], sqc, rs, bz, rv, rid[3], cnt[4]}
  typedef struct {
    logic        chk;
    logic        rst;
    logic        alloc;
    logic        rv;
    logic [2:0]  rid;
    logic        rcol;
    logic        miss;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [19:0] E(input logic ar, input int aid, input logic acol,
                                    input logic sq, input int sqid, input logic rs,
                                    input logic bz, input logic rv, input int rid,
                                    input int cnt);
    return {ar, 3'(aid), acol, sq, 3'(sqid), 1'b0, rs, bz, rv, 3'(rid), 4'(cnt)};
  endfunction

  function automatic logic [19:0] actual_bundle();
    return {alloc_ready, alloc_id, alloc_color, squash_valid, squash_id, squash_color,
            restore_valid, recover_busy, retire_valid, retire_id, inflight_count};
  endfunction

  task automatic add(input logic chk, input logic r, input logic al, input logic rv,
                     input int rid, input logic rcol, input logic miss,
                     input logic [19:0] exp);
    vec_t v;
    v.chk = chk; v.rst = r; v.alloc = al; v.rv = rv; v.rid = 3'(rid);
    v.rcol = rcol; v.miss = miss; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; alloc_req = 1'b0; resolve_valid = 1'b0;
    resolve_id = '0; resolve_color = 1'b0; resolve_miss = 1'b0;
  endtask

  task automatic build_table();
    // Fill 8 tags, retire tag 0, reuse it with color 1, then a stale miss.
    add(0,1,0,0,0,0,0, '0);
    for (int i = 0; i < 8; i++) add(1,0,1,0,0,0,0, E(1,i,0,0,0,0,0,0,0,i));
    add(1,0,0,1,0,0,0, E(0,0,1,0,0,0,0,0,0,8));
    add(1,0,0,0,0,0,0, E(0,0,1,0,0,0,0,0,0,8));
    add(1,0,1,0,0,0,0, E(1,0,1,0,0,0,0,1,0,7));
    add(1,0,0,1,0,0,1, E(0,1,1,0,0,0,0,0,0,8));
    add(1,0,0,0,0,0,0, E(0,1,1,0,0,0,0,0,0,8));
    // Tags 0..4, mispredict 1, stale resolves on 3, realloc gives 2.
    add(0,1,0,0,0,0,0, '0);
    for (int i = 0; i < 5; i++) add(1,0,1,0,0,0,0, E(1,i,0,0,0,0,0,0,0,i));
    add(1,0,0,1,1,0,1, E(1,5,0,0,0,0,0,0,0,5));
    add(1,0,0,0,0,0,0, E(0,2,0,1,1,1,1,0,0,2));
    add(1,0,0,1,3,0,0, E(0,2,0,1,1,0,1,0,0,2));
    add(1,0,0,1,3,0,1, E(1,2,0,0,1,0,0,0,0,2));
    add(1,0,1,0,0,0,0, E(1,2,0,0,1,0,0,0,0,2));
    add(1,0,0,0,0,0,0, E(1,3,0,0,1,0,0,0,0,3));
    // Nested recovery: miss 4, then miss 2 restarts, then miss 4 is stale.
    add(0,1,0,0,0,0,0, '0);
    for (int i = 0; i < 6; i++) add(1,0,1,0,0,0,0, E(1,i,0,0,0,0,0,0,0,i));
    add(1,0,0,1,4,0,1, E(1,6,0,0,0,0,0,0,0,6));
    add(1,0,0,1,2,0,1, E(0,5,0,1,4,1,1,0,0,5));
    add(1,0,0,1,4,0,1, E(0,3,0,1,2,1,1,0,0,3));
    add(1,0,0,0,0,0,0, E(0,3,0,1,2,0,1,0,0,3));
    add(1,0,0,0,0,0,0, E(1,3,0,0,2,0,0,0,0,3));
    // Alloc + miss on tag 0 together; tag 0 retires during recovery.
    add(0,1,0,0,0,0,0, '0);
    for (int i = 0; i < 3; i++) add(1,0,1,0,0,0,0, E(1,i,0,0,0,0,0,0,0,i));
    add(1,0,1,1,0,0,1, E(1,3,0,0,0,0,0,0,0,3));
    add(1,0,0,0,0,0,0, E(0,1,0,1,0,1,1,0,0,1));
    add(1,0,1,0,0,0,0, E(0,1,0,1,0,0,1,1,0,0));
    add(1,0,0,0,0,0,0, E(1,1,0,0,0,0,0,0,0,0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    idle_inputs();
    rst = 1'b1;
    build_table();
    tick();

    foreach (vecs[k]) begin
      rst           = vecs[k].rst;
      alloc_req     = vecs[k].alloc;
      resolve_valid = vecs[k].rv;
      resolve_id    = vecs[k].rid;
      resolve_color = vecs[k].rcol;
      resolve_miss  = vecs[k].miss;
      @(negedge clk);
      if (vecs[k].chk)
        check($sformatf("row%0d", k), 32'(actual_bundle()), 32'(vecs[k].exp));
      tick();
    end

    // Reset asserted in the middle of a recovery.
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    alloc_req = 1'b1;
    tick();
    tick();
    alloc_req = 1'b0;
    resolve_valid = 1'b1; resolve_id = 3'd1; resolve_miss = 1'b1;
    tick();
    idle_inputs();
    n = 0;
    while (!squash_valid && n < 4) begin
      tick();
      n++;
    end
    check("rstrec_squash_on", 32'(squash_valid), 32'd1);
    check("rstrec_busy_on", 32'(recover_busy), 32'd1);
    rst = 1'b1;
    tick();
    check("rstrec_squash_off", 32'(squash_valid), 32'd0);
    check("rstrec_busy_off", 32'(recover_busy), 32'd0);
    check("rstrec_restore", 32'(restore_valid), 32'd0);
    check("rstrec_count", 32'(inflight_count), 32'd0);
    check("rstrec_alloc_id", 32'(alloc_id), 32'd0);
    check("rstrec_alloc_color", 32'(alloc_color), 32'd0);
    check("rstrec_alloc_ready", 32'(alloc_ready), 32'd1);
    rst = 1'b0;
    tick();
    check("rstrec_idle_after", 32'({squash_valid, retire_valid, alloc_ready}), 32'b001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_tag_manager.md
Name: branch_tag_manager

Overview:
- Counterpart to the hazard controller's branch-miss output: allocates branch tags (id + color bit) at decode and consumes resolution results from execute.
- Tracks in-flight branches in program order and retires correctly predicted branches.
- On a mispredict, sequences recovery: rolls back younger tags, pulses a rename-checkpoint restore, and holds a squash broadcast for the issue queue and ROB.
- Sits between decode/rename and the execute branch unit.

Parameters:
- ID_W, 3, tag index width; NUM_IDS = 2^ID_W entries.
- RECOVER_CYCLES, 2, cycles squash_valid is held per recovery (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- alloc_req  in  1  decode has a branch needing a tag
- alloc_ready  out  1  tag available and not recovering
- alloc_id  out  ID_W  tag granted when alloc_req && alloc_ready
- alloc_color  out  1  color bit of alloc_id
- resolve_valid  in  1  execute resolved a branch
- resolve_id  in  ID_W  tag of resolved branch
- resolve_color  in  1  color of resolved branch
- resolve_miss  in  1  prediction was wrong
- squash_valid  out  1  kill all state younger than squash_id
- squash_id  out  ID_W  mispredicted tag
- squash_color  out  1  its color
- restore_valid  out  1  one-cycle pulse: restore rename checkpoint squash_id
- recover_busy  out  1  state == RECOVER
- retire_valid  out  1  one-cycle pulse: tag freed
- retire_id  out  ID_W  freed tag
- inflight_count  out  ID_W+1  allocated, unretired tags

Behaviour:
- Pointers head/tail are ID_W+1 bits: low bits = index, MSB = color. Per-entry state: valid, resolved.
- Age of entry p = (p - head) mod 2^(ID_W+1). Smaller age means older.
- Reset: head = tail = 0; all entries invalid; state IDLE; all outputs 0 except alloc_ready = 1 and alloc_id = 0. Reset asserted mid-recovery aborts the recovery immediately.
- full = (inflight_count == NUM_IDS); empty = (inflight_count == 0).
- alloc_ready = !full && state == IDLE. alloc_id and alloc_color are combinational from tail.
- Allocation fires on alloc_req && alloc_ready: the tail entry is set valid and unresolved, and tail increments (wrap flips the color).
- A resolve is accepted only if entry[resolve_id] is valid and its color equals resolve_color. Any other resolve is stale and ignored with no state change.
- Accepted resolve: the entry is marked resolved. The mispredicted branch itself stays valid and later retires normally.
- Accepted resolve with resolve_miss in IDLE:
  - tail <= {resolve_color, resolve_id} + 1; all younger entries are invalidated.
  - state <= RECOVER; counter <= RECOVER_CYCLES; squash_id/color are latched.
- A resolve_miss in the same cycle as an allocation overrides it: the new entry is discarded by the tail rollback.
- RECOVER:
  - squash_valid = 1 for exactly RECOVER_CYCLES cycles starting the cycle after acceptance.
  - restore_valid = 1 only in the first of those cycles. alloc_ready = 0.
  - The counter decrements each cycle; the state returns to IDLE after its last squash cycle.
- Resolve during RECOVER:
  - A miss on an accepted entry older than the current squash_id restarts recovery: latch the new tag, roll tail back, reload the counter, re-pulse restore_valid.
  - A correct resolve on an accepted entry marks it resolved.
  - Younger entries are already invalid, so resolves for them are stale.
- Retire: each cycle, if the head entry is valid and resolved, it is invalidated and head increments. retire_valid/retire_id are registered and pulse the following cycle. At most one retire per cycle; retire continues during RECOVER.
- Simultaneous retire and allocate in the same cycle are both allowed; inflight_count is unchanged.
- inflight_count = tail - head (ID_W+1 bits).

Test Plan:
- Reset, then 8 allocs with ID_W=3: ids 0..7 color 0; alloc_ready drops after the 8th; inflight_count = 8. Resolve id 0 correct → retire_valid with id 0 two cycles later; next alloc gets id 0 color 1.
- Allocate ids 0..4, mispredict id 1: the next two cycles show squash_valid = 1, squash_id = 1, restore_valid only in the first; inflight_count = 2; the next alloc after recovery gets id 2.
- Stale resolve: after the rollback above, resolve id 3 color 0 → no state change, no retire, no squash.
- Nested: ids 0..5 allocated, miss id 4, then miss id 2 during RECOVER → squash restarts with id 2, restore re-pulses, tail = 3; a miss on id 4 in the next cycle is ignored.
- Simultaneous alloc_req and miss on id 0 with ids 0..2 live → no new entry; tail = 1; alloc_ready = 0 the next cycle.
- Assert rst during RECOVER → squash_valid = 0 the next cycle; inflight_count = 0; alloc_id = 0 color 0.
